// File: rtl/led_breathe_multi.sv
// ---------------------------------------------------------------------------
// led_breathe_multi
//
// Multi-channel PWM LED driver. Every channel shares one free-running PWM
// frame counter (2^PWM_BITS clocks per frame) and one frame prescaler that
// sets how often the breathing ramps and blink phases advance. Each channel
// independently runs in one of four runtime modes:
//   00 off      - never lit
//   01 steady   - duty = level
//   10 breathe  - duty follows a saturating triangle ramp (brightness)
//   11 blink    - duty alternates between level and 0 on every update tick
//
// Duty values are latched into per-channel shadow registers only on the last
// cycle of a frame, so a mode/level change never produces a partial frame.
// Breathing channels come out of reset with staggered brightness values so
// a multi-channel breathe does not start in lock-step.
//
// Ports
//   clk          system clock (48 MHz SB_HFOSC net on iCE40)
//   reset        synchronous, active-high reset
//   mode         per-channel mode, channel i at [2i+1:2i]
//   level        per-channel steady / blink-on level,
//                channel i at [PWM_BITS*i +: PWM_BITS]; also the starting
//                brightness when a channel enters breathe mode
//   step         breathing increment per update tick (shared)
//   rate         frames per update tick, minus one (shared)
//   led          registered PWM outputs; ACTIVE_LOW=1 means 0 is lit
//   frame_tick   one-cycle pulse on the last cycle of each PWM frame
//   update_tick  one-cycle pulse on cycles where ramp/blink state advances
// ---------------------------------------------------------------------------
module led_breathe_multi #(
    parameter int CHANNELS      = 3,
    parameter int PWM_BITS      = 12,
    parameter int PRESCALE_BITS = 16,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2*CHANNELS-1:0]        mode,
    input  logic [PWM_BITS*CHANNELS-1:0] level,
    input  logic [PWM_BITS-1:0]          step,
    input  logic [PRESCALE_BITS-1:0]     rate,
    output logic [CHANNELS-1:0]          led,
    output logic                         frame_tick,
    output logic                         update_tick
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_STEADY  = 2'b01,
        MODE_BREATHE = 2'b10,
        MODE_BLINK   = 2'b11
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [PWM_BITS-1:0] PWM_MAX   = {PWM_BITS{1'b1}};
    // Pad level that means "dark" for this board's LED wiring.
    localparam logic                LED_UNLIT = ACTIVE_LOW;

    // Staggered start point for channel idx: idx/CHANNELS of full scale.
    // Computed with 32 spare bits so idx * 2^PWM_BITS never overflows.
    function automatic logic [PWM_BITS-1:0] reset_bright(input int idx);
        logic [PWM_BITS+31:0] scaled;
        scaled = (PWM_BITS+32)'(idx) << PWM_BITS;
        return PWM_BITS'(scaled / (PWM_BITS+32)'(CHANNELS));
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [PWM_BITS-1:0]      pwm_cnt_q,   pwm_cnt_d;
    logic [PRESCALE_BITS-1:0] presc_cnt_q, presc_cnt_d;

    logic [PWM_BITS-1:0] duty_q   [CHANNELS];
    logic [PWM_BITS-1:0] duty_d   [CHANNELS];
    logic [PWM_BITS-1:0] bright_q [CHANNELS];
    logic [PWM_BITS-1:0] bright_d [CHANNELS];
    dir_e                dir_q    [CHANNELS];
    dir_e                dir_d    [CHANNELS];
    logic                phase_q  [CHANNELS];
    logic                phase_d  [CHANNELS];
    mode_e               mode_q   [CHANNELS];
    mode_e               mode_d   [CHANNELS];

    logic [CHANNELS-1:0] led_q, led_d;

    // Per-channel views of the packed input buses.
    mode_e               ch_mode  [CHANNELS];
    logic [PWM_BITS-1:0] ch_level [CHANNELS];
    logic                entering [CHANNELS];
    logic [PWM_BITS-1:0] target   [CHANNELS];

    // -----------------------------------------------------------------------
    // Input unpacking and mode-entry detection
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            ch_mode[i]  = mode_e'(mode[2*i +: 2]);
            ch_level[i] = level[PWM_BITS*i +: PWM_BITS];
            // A mode is "entered" on the first cycle it differs from the
            // mode seen on the previous cycle.
            entering[i] = (ch_mode[i] != mode_q[i]);
        end
    end

    // -----------------------------------------------------------------------
    // Shared timebase: PWM frame counter and update prescaler
    // -----------------------------------------------------------------------
    always_comb begin
        frame_tick  = (pwm_cnt_q == PWM_MAX);
        update_tick = frame_tick && (presc_cnt_q == rate);

        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        presc_cnt_d = presc_cnt_q;

        // If rate drops below the current count the prescaler simply runs
        // on, wraps, and matches on the way back round.
        if (frame_tick) begin
            if (presc_cnt_q == rate) begin
                presc_cnt_d = '0;
            end else begin
                presc_cnt_d = presc_cnt_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Per-channel duty selection, ramp/blink update and PWM compare
    // -----------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            target[i]   = '0;
            bright_d[i] = bright_q[i];
            dir_d[i]    = dir_q[i];
            phase_d[i]  = phase_q[i];
            mode_d[i]   = ch_mode[i];

            case (ch_mode[i])
                MODE_OFF:     target[i] = '0;
                MODE_STEADY:  target[i] = ch_level[i];
                MODE_BREATHE: target[i] = bright_q[i];
                MODE_BLINK:   target[i] = phase_q[i] ? ch_level[i] : '0;
                default:      target[i] = '0;
            endcase

            // Shadow only reloads on the last cycle of the frame, so the new
            // duty starts exactly at pwm_cnt == 0.
            duty_d[i] = frame_tick ? target[i] : duty_q[i];

            // Compare uses the current count; the result is registered, so
            // the pad shows it one cycle later.
            led_d[i] = (pwm_cnt_q < duty_q[i]) ? ~LED_UNLIT : LED_UNLIT;

            // Breathing ramp. Entry wins over a coincident update tick.
            // Comparisons are arranged so nothing ever wraps:
            // PWM_MAX - step cannot underflow.
            if (ch_mode[i] == MODE_BREATHE) begin
                if (entering[i]) begin
                    bright_d[i] = ch_level[i];
                    dir_d[i]    = DIR_UP;
                end else if (update_tick && (step != '0)) begin
                    if (dir_q[i] == DIR_UP) begin
                        if (bright_q[i] >= (PWM_MAX - step)) begin
                            bright_d[i] = PWM_MAX;
                            dir_d[i]    = DIR_DOWN;
                        end else begin
                            bright_d[i] = bright_q[i] + step;
                        end
                    end else begin
                        if (bright_q[i] <= step) begin
                            bright_d[i] = '0;
                            dir_d[i]    = DIR_UP;
                        end else begin
                            bright_d[i] = bright_q[i] - step;
                        end
                    end
                end
            end

            // Blink starts in the lit phase and flips on every update tick.
            if (ch_mode[i] == MODE_BLINK) begin
                if (entering[i]) begin
                    phase_d[i] = 1'b1;
                end else if (update_tick) begin
                    phase_d[i] = ~phase_q[i];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q   <= '0;
            presc_cnt_q <= '0;
            led_q       <= {CHANNELS{LED_UNLIT}};
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i]   <= '0;
                bright_q[i] <= reset_bright(i);
                dir_q[i]    <= DIR_UP;
                phase_q[i]  <= 1'b0;
                mode_q[i]   <= MODE_OFF;
            end
        end else begin
            pwm_cnt_q   <= pwm_cnt_d;
            presc_cnt_q <= presc_cnt_d;
            led_q       <= led_d;
            for (int i = 0; i < CHANNELS; i++) begin
                duty_q[i]   <= duty_d[i];
                bright_q[i] <= bright_d[i];
                dir_q[i]    <= dir_d[i];
                phase_q[i]  <= phase_d[i];
                mode_q[i]   <= mode_d[i];
            end
        end
    end

    assign led = led_q;

endmodule

// File: tb/tb_led_breathe_multi.sv
// ---------------------------------------------------------------------------
// tb_led_breathe_multi
//
// Two instances of led_breathe_multi (active-high and active-low pads) share
// one set of stimulus. A cycle-level reference model written with plain
// integer arithmetic predicts every led bit, both ticks, and each channel's
// brightness/direction; directed steps add fixed expected values taken
// straight from the intended behaviour.
// ---------------------------------------------------------------------------
module tb_led_breathe_multi;

  localparam int CH    = 3;
  localparam int PB    = 4;
  localparam int SB    = 4;
  localparam int FRAME = 1 << PB;
  localparam int PMAX  = FRAME - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [2*CH-1:0]  mode;
  logic [PB*CH-1:0] level;
  logic [PB-1:0]    step;
  logic [SB-1:0]    rate;
  logic [CH-1:0]    led_h, led_l;
  logic             ft_h, ut_h, ft_l, ut_l;

  int tests = 0;
  int fails = 0;

  led_breathe_multi #(
    .CHANNELS(CH), .PWM_BITS(PB), .PRESCALE_BITS(SB), .ACTIVE_LOW(1'b0)
  ) dut_h (
    .clk(clk), .reset(reset), .mode(mode), .level(level), .step(step),
    .rate(rate), .led(led_h), .frame_tick(ft_h), .update_tick(ut_h)
  );

  led_breathe_multi #(
    .CHANNELS(CH), .PWM_BITS(PB), .PRESCALE_BITS(SB), .ACTIVE_LOW(1'b1)
  ) dut_l (
    .clk(clk), .reset(reset), .mode(mode), .level(level), .step(step),
    .rate(rate), .led(led_l), .frame_tick(ft_l), .update_tick(ut_l)
  );

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "bench timeout");
  end

  // ---------------- reference model ----------------
  int m_cnt, m_presc;
  int m_duty   [CH];
  int m_bright [CH];
  int m_mode_q [CH];
  bit m_up     [CH];
  bit m_phase  [CH];
  bit m_lit    [CH];

  task automatic model_step();
    bit ft, ut;
    int md, lv, tgt, nb, stp;
    stp = int'(step);
    if (reset) begin
      m_cnt   = 0;
      m_presc = 0;
      for (int i = 0; i < CH; i++) begin
        m_duty[i]   = 0;
        m_bright[i] = (i * FRAME) / CH;
        m_up[i]     = 1'b1;
        m_phase[i]  = 1'b0;
        m_mode_q[i] = 0;
        m_lit[i]    = 1'b0;
      end
      return;
    end
    ft = (m_cnt == PMAX);
    ut = ft && (m_presc == int'(rate));
    for (int i = 0; i < CH; i++) begin
      md = int'(mode[2*i +: 2]);
      lv = int'(level[PB*i +: PB]);
      m_lit[i] = (m_cnt < m_duty[i]);
      case (md)
        1:       tgt = lv;
        2:       tgt = m_bright[i];
        3:       tgt = m_phase[i] ? lv : 0;
        default: tgt = 0;
      endcase
      if (ft) m_duty[i] = tgt;
      if (md == 2) begin
        if (md != m_mode_q[i]) begin
          m_bright[i] = lv;
          m_up[i]     = 1'b1;
        end else if (ut && stp > 0) begin
          if (m_up[i]) begin
            nb = m_bright[i] + stp;
            if (nb >= PMAX) begin m_bright[i] = PMAX; m_up[i] = 1'b0; end
            else m_bright[i] = nb;
          end else begin
            nb = m_bright[i] - stp;
            if (nb <= 0) begin m_bright[i] = 0; m_up[i] = 1'b1; end
            else m_bright[i] = nb;
          end
        end
      end
      if (md == 3) begin
        if (md != m_mode_q[i]) m_phase[i] = 1'b1;
        else if (ut)           m_phase[i] = !m_phase[i];
      end
      m_mode_q[i] = md;
    end
    m_cnt = (m_cnt + 1) % FRAME;
    if (ft) m_presc = (m_presc == int'(rate)) ? 0 : (m_presc + 1) % (1 << SB);
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    bit eft, eut;
    eft = (m_cnt == PMAX);
    eut = eft && (m_presc == int'(rate));
    for (int i = 0; i < CH; i++) begin
      chk($sformatf("led_hi[%0d]", i), led_h[i], m_lit[i]);
      chk($sformatf("led_lo[%0d]", i), led_l[i], !m_lit[i]);
      chk($sformatf("bright[%0d]", i), dut_h.bright_q[i], m_bright[i]);
      chk($sformatf("dir[%0d]", i), dut_h.dir_q[i], m_up[i] ? 0 : 1);
    end
    chk("frame_tick_hi", ft_h, eft);
    chk("frame_tick_lo", ft_l, eft);
    chk("update_tick_hi", ut_h, eut);
    chk("update_tick_lo", ut_l, eut);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic set_ch(input int i, input logic [1:0] md, input logic [PB-1:0] lv);
    mode[2*i +: 2]   = md;
    level[PB*i +: PB] = lv;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int cnt, lit, k, dark;
    int seq [8];
    int blink_exp [10];
    seq       = '{0, 6, 12, 15, 9, 3, 0, 6};
    blink_exp = '{0, 15, 15, 15, 0, 0, 0, 15, 15, 15};

    reset = 1'b1; mode = '0; level = '0; step = '0; rate = '0;
    tick(); tick();
    chk("rst_bright0", dut_h.bright_q[0], 0);
    chk("rst_bright1", dut_h.bright_q[1], 5);
    chk("rst_bright2", dut_h.bright_q[2], 10);
    chk("rst_cnt", dut_h.pwm_cnt_q, 0);
    chk("rst_led_hi", led_h, 3'b000);
    chk("rst_led_lo", led_l, 3'b111);
    reset = 1'b0;

    // frame_tick once every 16 cycles
    cnt = 0;
    for (int n = 0; n < 48; n++) begin tick(); if (ft_h) cnt++; end
    chk("ft_count", cnt, 3);

    // steady level 4, then a mid-frame change to 9
    set_ch(0, 2'b01, 4'd4);
    repeat (16) tick();
    cnt = 0; repeat (16) begin tick(); if (led_h[0]) cnt++; end
    chk("steady_4", cnt, 4);
    cnt = 0; repeat (8) begin tick(); if (led_h[0]) cnt++; end
    set_ch(0, 2'b01, 4'd9);
    repeat (8) begin tick(); if (led_h[0]) cnt++; end
    chk("steady_mid_change", cnt, 4);
    cnt = 0; repeat (16) begin tick(); if (led_h[0]) cnt++; end
    chk("steady_9", cnt, 9);

    // breathe ramp with saturation at both ends
    set_ch(0, 2'b10, 4'd0); step = 4'd6; rate = '0;
    tick();
    chk("breathe_0", dut_h.bright_q[0], seq[0]);
    repeat (15) tick();
    chk("breathe_1", dut_h.bright_q[0], seq[1]);
    for (int n = 2; n < 8; n++) begin
      repeat (16) tick();
      chk($sformatf("breathe_%0d", n), dut_h.bright_q[0], seq[n]);
    end

    // blink at rate=2: 3 frames lit, 3 frames dark
    reset = 1'b1; mode = '0; level = '0; step = '0; rate = 4'd2;
    set_ch(1, 2'b11, 4'd15);
    tick(); tick();
    reset = 1'b0;
    cnt = 0;
    for (int f = 0; f < 10; f++) begin
      lit = 0;
      repeat (16) begin tick(); if (led_h[1]) lit++; if (ut_h) cnt++; end
      chk($sformatf("blink_frame_%0d", f), lit, blink_exp[f]);
    end
    chk("blink_update_count", cnt, 3);

    // step = 0 holds brightness across updates
    reset = 1'b1; mode = '0; level = '0; step = '0; rate = '0;
    tick(); tick();
    set_ch(2, 2'b10, 4'd3);
    reset = 1'b0;
    cnt = 0;
    repeat (160) begin tick(); if (ut_h) cnt++; end
    chk("step0_updates", cnt, 10);
    chk("step0_bright", dut_h.bright_q[2], 3);

    // re-enter breathe on an update_tick cycle: entry wins
    set_ch(2, 2'b00, 4'd3);
    tick();
    k = 0;
    while (!ut_h && k < 32) begin tick(); k++; end
    chk("wait_update", ut_h, 1'b1);
    set_ch(2, 2'b10, 4'd7); step = 4'd5;
    tick();
    chk("reenter_bright", dut_h.bright_q[2], 7);
    chk("reenter_dir", dut_h.dir_q[2], 0);

    // randomized segments against the model
    reset = 1'b1; tick(); reset = 1'b0;
    for (int s = 0; s < 30; s++) begin
      for (int i = 0; i < CH; i++) set_ch(i, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      step = 4'($urandom_range(0, 15));
      rate = 4'($urandom_range(0, 3));
      repeat ($urandom_range(5, 60)) tick();
    end

    // reset mid-frame: pads go dark on the very next edge
    for (int i = 0; i < CH; i++) set_ch(i, 2'b01, 4'd15);
    step = '0; rate = '0;
    repeat (40) tick();
    k = 0;
    while (dut_h.pwm_cnt_q != 7 && k < 32) begin tick(); k++; end
    chk("wait_cnt7", dut_h.pwm_cnt_q, 7);
    chk("pre_reset_lo", led_l, 3'b000);
    reset = 1'b1;
    tick();
    chk("mid_reset_lo", led_l, 3'b111);
    chk("mid_reset_hi", led_h, 3'b000);
    chk("mid_reset_cnt", dut_h.pwm_cnt_q, 0);
    reset = 1'b0;
    dark = 0;
    repeat (16) begin tick(); if (led_l == 3'b111) dark++; end
    chk("duty0_frame_lo", dark, 16);
    repeat (16) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
